// File: rtl/uart_echo_pkg.sv
// Shared FSM state type and ASCII constants for the uart_line_echo controller.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    CAPTURE  = 3'd2,
    DRAIN    = 3'd3,
    TX_ISSUE = 3'd4,
    TX_WAIT  = 3'd5,
    LF_ISSUE = 3'd6
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;

endpackage

// File: rtl/uart_line_echo_buf.sv
// Line buffer for uart_line_echo: DEPTH x 8 registers, synchronous write, combinational read.
module echo_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Storage write; contents are deliberately left unreset, level tracks validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_line_echo.sv
// Byte/line echo controller between the UART RX FIFO read side and TX start side.
// Define UART_LINE_ECHO_CRLF_EN to follow every echoed terminator with an LF byte.
module uart_line_echo #(
  parameter int         DEPTH = 64,
  parameter logic [7:0] TERM  = uart_echo_pkg::CR,
  parameter logic [7:0] BS    = uart_echo_pkg::BS,
  parameter int         CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         line_mode,
  input  logic                         uart_rx_ready,
  output logic                         uart_rx_read,
  input  logic [7:0]                   uart_rx_byte,
  input  logic                         uart_tx_full,
  output logic                         uart_tx_start,
  output logic [7:0]                   uart_tx_data_in,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             lines_echoed
);

  import uart_echo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  logic             mode_r;
  logic             rx_read_r;
  logic             tx_start_r;
  logic             lf_done_r;
  logic [7:0]       byte_r;
  logic [7:0]       tx_data_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [CNT_W-1:0] lines_r;

  logic             wr_en_s;
  logic [7:0]       rd_data_s;
  logic             last_s;
  logic             lf_want_s;

  assign wr_en_s = (state_r == CAPTURE) && mode_r && (uart_rx_byte != BS);
  assign last_s  = (LW'(rd_ptr_r) + LVL_ONE) >= level_r;

`ifdef UART_LINE_ECHO_CRLF_EN
  // A terminator just went out and its LF has not been issued yet.
  assign lf_want_s = !lf_done_r && (tx_data_r == TERM);
`else
  assign lf_want_s = 1'b0;
`endif

  echo_line_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (level_r[AW-1:0]),
    .wr_data (uart_rx_byte),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Control FSM: RX pop handshake, line editing, flush sequencing and line counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      mode_r     <= 1'b0;
      rx_read_r  <= 1'b0;
      tx_start_r <= 1'b0;
      lf_done_r  <= 1'b0;
      byte_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      lines_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          mode_r <= line_mode;
          if (uart_rx_ready) begin
            rx_read_r <= 1'b1;
            state_r   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          rx_read_r <= 1'b0;
          state_r   <= CAPTURE;
        end

        CAPTURE: begin
          if (!mode_r) begin
            byte_r  <= uart_rx_byte;
            state_r <= TX_ISSUE;
          end else if (uart_rx_byte == BS) begin
            if (level_r != {LW{1'b0}}) begin
              level_r <= level_r - LVL_ONE;
            end
            state_r <= IDLE;
          end else begin
            level_r <= level_r + LVL_ONE;
            if ((uart_rx_byte == TERM) || ((level_r + LVL_ONE) == DEPTH_L)) begin
              rd_ptr_r <= {AW{1'b0}};
              state_r  <= DRAIN;
            end else begin
              state_r <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (!uart_tx_full) begin
            tx_data_r  <= rd_data_s;
            tx_start_r <= 1'b1;
            state_r    <= TX_WAIT;
          end
        end

        TX_ISSUE: begin
          if (!uart_tx_full) begin
            tx_data_r  <= byte_r;
            tx_start_r <= 1'b1;
            state_r    <= TX_WAIT;
          end
        end

`ifdef UART_LINE_ECHO_CRLF_EN
        LF_ISSUE: begin
          if (!uart_tx_full) begin
            tx_data_r  <= LF;
            tx_start_r <= 1'b1;
            lf_done_r  <= 1'b1;
            state_r    <= TX_WAIT;
          end
        end
`endif

        // Line completion (level clear, count) waits until any trailing LF is out.
        TX_WAIT: begin
          tx_start_r <= 1'b0;
          lf_done_r  <= 1'b0;
          if (mode_r && !last_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            state_r  <= DRAIN;
          end else if (lf_want_s) begin
            state_r <= LF_ISSUE;
          end else begin
            if (mode_r) begin
              level_r <= {LW{1'b0}};
              lines_r <= lines_r + CNT_ONE;
            end
            state_r <= IDLE;
          end
        end

        default: begin
          rx_read_r  <= 1'b0;
          tx_start_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign uart_rx_read    = rx_read_r;
  assign uart_tx_start   = tx_start_r;
  assign uart_tx_data_in = tx_data_r;
  assign level           = level_r;
  assign lines_echoed    = lines_r;
  assign busy            = (state_r != IDLE) || (level_r != {LW{1'b0}});

endmodule

// File: doc/uart_line_echo.md
Name: uart_line_echo

Overview:
- Parametrised successor to the single-byte UART echo controller.
- Sits between the uart block's RX FIFO read interface and its TX start interface.
- Two modes:
  - Byte mode: every received byte is echoed immediately.
  - Line mode: bytes are buffered up to DEPTH and the whole line is echoed on terminator or buffer full.
- Line mode supports backspace editing, TX back-pressure and status counters.

Parameters:
- DEPTH, 64: line buffer entries; power of two, 4..256.
- TERM, 8'h0D: line terminator byte.
- BS, 8'h08: backspace byte, line mode only.
- CNT_W, 16: width of lines_echoed counter.

Ports:
- clk  in  1  system clock (PLL clock domain).
- rst  in  1  asynchronous active-high reset.
- line_mode  in  1  1 = line mode, 0 = byte mode; sampled only in IDLE.
- uart_rx_ready  in  1  RX FIFO non-empty.
- uart_rx_read  out  1  one-cycle RX FIFO pop strobe.
- uart_rx_byte  in  8  RX FIFO head; valid the cycle after uart_rx_read deasserts.
- uart_tx_full  in  1  TX FIFO full; no start while high.
- uart_tx_start  out  1  one-cycle TX push strobe.
- uart_tx_data_in  out  8  TX byte; held stable with and after uart_tx_start.
- busy  out  1  high whenever state != IDLE or level != 0.
- level  out  $clog2(DEPTH+1)  bytes currently buffered.
- lines_echoed  out  CNT_W  completed line flushes; wraps modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous: assertion immediately forces the following, aborting any operation mid-flight. No partial line survives reset.
  - state = IDLE
  - uart_rx_read = 0, uart_tx_start = 0, uart_tx_data_in = 0
  - level = 0, lines_echoed = 0, busy = 0, read pointer = 0
- Strobes: all strobes are registered and are single-cycle pulses.
- IDLE:
  - Latch line_mode into mode_q.
  - If uart_rx_ready: assert uart_rx_read, go to RD_WAIT.
- RD_WAIT: deassert uart_rx_read, go to CAPTURE.
- CAPTURE (sample uart_rx_byte as b):
  - Byte mode: go to TX_ISSUE with b.
  - Line mode, b == BS:
    - level > 0: level--.
    - level == 0: ignored.
    - Either way, go to IDLE. No echo, nothing stored.
  - Line mode, otherwise:
    - Store b at buf[level], level++.
    - If b == TERM or new level == DEPTH: reset read pointer to 0 and go to DRAIN.
    - Else go to IDLE.
- DRAIN:
  - If uart_tx_full: stay.
  - Else: drive uart_tx_data_in = buf[rd_ptr], pulse uart_tx_start, go to TX_WAIT.
- TX_ISSUE (byte mode):
  - If uart_tx_full: stay.
  - Else: drive byte, pulse start, go to TX_WAIT.
- TX_WAIT: deassert start, then:
  - Byte mode: go to IDLE.
  - Line mode, rd_ptr + 1 < level: rd_ptr++, go to DRAIN.
  - Line mode, last byte sent: level = 0, lines_echoed++, go to IDLE.
- Latency:
  - Byte mode: start asserts 4 cycles after the IDLE cycle that sees ready, when TX is not full.
  - Line mode flush: 2 cycles per byte when TX is not full.
- Boundary conditions:
  - A full buffer with no TERM flushes exactly DEPTH bytes.
  - TERM is stored and echoed as the last byte.
  - A buffer consisting of TERM alone flushes 1 byte.
  - RX is not read during DRAIN; the RX FIFO absorbs incoming bytes.
  - line_mode changes take effect only at IDLE. A mode change never truncates a pending line: the partial line stays buffered and the next line-mode terminator flushes it.
  - In byte mode, BS and TERM are echoed verbatim.

Optional Feature:
- Macro: UART_LINE_ECHO_CRLF_EN.
- Defined: after the TERM byte of a line flush (line mode) or after an echoed TERM (byte mode), the controller issues one extra byte 8'h0A through TX_ISSUE/TX_WAIT, honouring uart_tx_full.
  - lines_echoed increments after the LF.
  - Adds state LF_ISSUE.
- Undefined: no LF is generated; the state is absent.

Decomposition:
- Package uart_echo_pkg:
  - state enum {IDLE, RD_WAIT, CAPTURE, DRAIN, TX_ISSUE, TX_WAIT, LF_ISSUE}.
  - ASCII constants CR = 8'h0D, LF = 8'h0A, BS = 8'h08.
- Sub-module echo_line_buf:
  - DEPTH x 8 register array.
  - Synchronous write port.
  - Combinational read port.
  - No reset on the contents.

Test Plan:
- Byte mode, RX bytes 0x41, 0x42 with TX never full -> TX sequence 0x41, 0x42; each start is 1 cycle wide and occurs 4 cycles after ready is seen; lines_echoed = 0.
- Line mode, RX "AB\r" (0x41, 0x42, 0x0D) -> no TX until 0x0D, then 0x41, 0x42, 0x0D at 2-cycle spacing; lines_echoed = 1; level = 0.
- Line mode, RX 0x41, 0x08, 0x08, 0x43, 0x0D -> TX 0x43, 0x0D only; the second BS at level 0 is ignored.
- Line mode, DEPTH = 4, RX 0x31..0x35 -> flush of 0x31..0x34 after the 4th byte, then 0x35 buffered with level = 1; lines_echoed = 1.
- uart_tx_full held high for 10 cycles during DRAIN -> no start while full; the byte order is preserved after release.
- rst pulsed mid-DRAIN with level = 3 -> outputs drop immediately to reset values; a subsequent line echoes only new bytes.
- With UART_LINE_ECHO_CRLF_EN defined, RX "A\r" in line mode -> TX 0x41, 0x0D, 0x0A.
